dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 8: consecutive lost arbitration cycles after which port 1 is force-granted (fixed-priority mode only).
REQ-002 Parameter ADDR_W, default 32: address width of both ports and of the memory side.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 pN_valid  in  1  request valid, port N (N=0 pipeline MEM stage, N=1 loader/debug).
REQ-006 pN_ready  out  1  request accepted this cycle; handshake when pN_valid && pN_ready.
REQ-007 pN_we  in  1  1 = store word, 0 = load word.
REQ-008 pN_addr  in  ADDR_W  byte address; word-aligned required.
REQ-009 pN_wdata  in  32  store data.
REQ-010 pN_rvalid  out  1  one-cycle pulse: load data or error response valid.
REQ-011 pN_rdata  out  32  registered load data; held until next pN_rvalid.
REQ-012 pN_err  out  1  qualified by pN_rvalid; misaligned access.
REQ-013 mem_read, mem_write  out  1 each  drive single-port data memory (combinational read, synchronous write).
REQ-014 mem_addr  out  ADDR_W;  mem_wdata  out  32;  mem_rdata  in  32.

Function
REQ-015 At most one handshake per cycle; ready to the winner only; loser's ready low, its request held by requester.
REQ-016 Winner's request drives mem_* combinationally in the accept cycle; mem_read = ~we, mem_write = we; no request -> mem_read = mem_write = 0, mem_addr/mem_wdata = 0.
REQ-017 Load: mem_rdata captured at accept edge; pN_rvalid = 1, pN_rdata valid next cycle (latency 1).
REQ-018 Store: memory written at accept edge; pN_rvalid pulses next cycle with pN_err = 0, pN_rdata unchanged.
REQ-019 Misaligned (addr[1:0] != 0): still handshaken, mem_read = mem_write = 0, next cycle pN_rvalid = 1, pN_err = 1, pN_rdata unchanged.
REQ-020 Back-to-back: one port may be accepted every cycle; responses pipeline in order, one per cycle.
REQ-021 Fixed-priority mode: port 0 wins when both valid, except when starve counter == STARVE_LIMIT, then port 1 wins.
REQ-022 Starve counter: increments when p1_valid && port 0 granted; clears when port 1 granted or p1_valid = 0; saturates at STARVE_LIMIT.
REQ-023 Sole requester always wins the same cycle (no idle bubble).
REQ-024 pN_ready may depend combinationally on pN_valid, never pN_ready -> pN_valid loop assumed by requesters.

Reset
REQ-025 While rst_n = 0: pN_ready = 0, pN_rvalid = 0, pN_err = 0, pN_rdata = 0, mem_read = mem_write = 0, starve counter = 0, last-grant pointer = port 1.
REQ-026 Reset asserted mid-access aborts the pending response; no rvalid is issued after release for the aborted access.

Configuration
REQ-027 Macro DMEM_ARB_RR_EN defined: round-robin; on contention the port not granted last wins; pointer updates on every handshake; starve counter and STARVE_LIMIT unused.
REQ-028 Macro undefined: fixed priority with starvation guard per REQ-021/REQ-022.

Structure
REQ-029 Package dmem_arb_pkg holds port-index constants (PORT_CPU = 0, PORT_DBG = 1), the response struct (rvalid, err, rdata) and the alignment-check function.
REQ-030 Sub-module dmem_arb_pick: pure combinational winner selection from valids, last-grant and starve-limit-hit; instantiated once.

Verification
REQ-031 p0 load addr 0x10 alone, mem word4 = 0xDEADBEEF -> p0_ready same cycle, next cycle p0_rvalid = 1, p0_rdata = 0xDEADBEEF.
REQ-032 p0 and p1 stores same cycle (0x04<-0x11, 0x08<-0x22), fixed mode -> p0 accepted cycle 0, p1 cycle 1; readback yields 0x11, 0x22.
REQ-033 p0 valid every cycle, p1 valid continuously, STARVE_LIMIT = 8, fixed mode -> p1 granted on 9th cycle, counter clears.
REQ-034 RR build, both valid 6 cycles -> grants alternate 0,1,0,1,0,1 (first grant port 0).
REQ-035 p1 load addr 0x0A -> mem_read = 0, next cycle p1_rvalid = 1, p1_err = 1.
REQ-036 rst_n low one cycle after a p0 load handshake -> no p0_rvalid after release, all outputs 0.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter.
//   PORT_CPU / PORT_DBG : port indices (0 = pipeline MEM stage, 1 = loader/debug)
//   dmem_rsp_t          : per-port response register contents
//   addr_aligned()      : word-alignment check on the two address LSBs
package dmem_arb_pkg;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DBG = 1'b1;

    typedef struct packed {
        logic        rvalid;
        logic        err;
        logic [31:0] rdata;
    } dmem_rsp_t;

    function automatic logic addr_aligned(input logic [1:0] addr_lsb);
        return (addr_lsb == 2'b00);
    endfunction

endpackage

// File: rtl/dmem_arb_pick.sv
// Combinational winner selection for the two-port data-memory arbiter.
// Build option: define DMEM_ARB_RR_EN for round-robin tie-break, otherwise
// port 0 has priority unless the starvation guard has fired.
//   p0_valid, p1_valid : (reset-qualified) request valids
//   last_grant         : port granted at the most recent handshake
//   starve_hit         : port 1 has lost STARVE_LIMIT consecutive cycles
//   grant_valid        : some port is granted this cycle
//   grant_port         : index of the granted port
module dmem_arb_pick (
    input  logic p0_valid,
    input  logic p1_valid,
    input  logic last_grant,
    input  logic starve_hit,
    output logic grant_valid,
    output logic grant_port
);
    import dmem_arb_pkg::*;

    // A sole requester always wins; only contention consults the tie-break.
    always_comb begin
        grant_valid = p0_valid | p1_valid;
        grant_port  = PORT_CPU;
        if (p0_valid && p1_valid) begin
`ifdef DMEM_ARB_RR_EN
            grant_port = ~last_grant;
`else
            grant_port = starve_hit ? PORT_DBG : PORT_CPU;
`endif
        end else if (p1_valid) begin
            grant_port = PORT_DBG;
        end else begin
            grant_port = PORT_CPU;
        end
    end

    // The tie-break input not used by this build is parked here.
`ifdef DMEM_ARB_RR_EN
    logic unused_starve_hit_s;
    assign unused_starve_hit_s = starve_hit;
`else
    logic unused_last_grant_s;
    assign unused_last_grant_s = last_grant;
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-port data memory (combinational
// read, synchronous write). One handshake per cycle; responses come back one
// cycle after acceptance on a registered rvalid/rdata/err per port.
// Build option: DMEM_ARB_RR_EN selects round-robin arbitration; when
// undefined, port 0 has fixed priority with a starvation guard for port 1.
//   clk, rst_n                         : clock, async active-low reset
//   pN_valid/we/addr/wdata, pN_ready   : request channel, port N
//   pN_rvalid/rdata/err                : response channel, port N
//   mem_read/write/addr/wdata/rdata    : memory side
module dmem_arbiter #(
    parameter int STARVE_LIMIT = 8,
    parameter int ADDR_W       = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              p0_valid,
    output logic              p0_ready,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [31:0]       p0_wdata,
    output logic              p0_rvalid,
    output logic [31:0]       p0_rdata,
    output logic              p0_err,
    input  logic              p1_valid,
    output logic              p1_ready,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [31:0]       p1_wdata,
    output logic              p1_rvalid,
    output logic [31:0]       p1_rdata,
    output logic              p1_err,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);
    import dmem_arb_pkg::*;

    // Next response for one port: load data is captured only for an aligned
    // load; stores and misaligned accesses keep the previous rdata.
    function automatic dmem_rsp_t next_rsp(input logic hs, input logic ok,
                                           input logic we, input logic [31:0] rd,
                                           input logic [31:0] prev_rdata);
        dmem_rsp_t r;
        r.rvalid = hs;
        r.err    = hs & ~ok;
        if (hs && ok && !we) begin
            r.rdata = rd;
        end else begin
            r.rdata = prev_rdata;
        end
        return r;
    endfunction

    logic              v0_s, v1_s;
    logic              grant_valid_s, grant_port_s, starve_hit_s;
    logic              hs0_s, hs1_s;
    logic              win_we_s, win_ok_s;
    logic [ADDR_W-1:0] win_addr_s;
    logic [31:0]       win_wdata_s;
    logic              last_grant_d, last_grant_q;
    dmem_rsp_t         rsp0_d, rsp0_q, rsp1_d, rsp1_q;

    // Requests are ignored while reset is asserted so ready and the memory
    // strobes stay low even though they are combinational.
    assign v0_s = p0_valid & rst_n;
    assign v1_s = p1_valid & rst_n;

    dmem_arb_pick u_pick (
        .p0_valid   (v0_s),
        .p1_valid   (v1_s),
        .last_grant (last_grant_q),
        .starve_hit (starve_hit_s),
        .grant_valid(grant_valid_s),
        .grant_port (grant_port_s)
    );

    assign hs0_s    = grant_valid_s & (grant_port_s == PORT_CPU);
    assign hs1_s    = grant_valid_s & (grant_port_s == PORT_DBG);
    assign p0_ready = hs0_s;
    assign p1_ready = hs1_s;

    // Route the winner's request to the memory port; zeros when idle.
    always_comb begin
        win_we_s    = 1'b0;
        win_addr_s  = '0;
        win_wdata_s = 32'h0000_0000;
        if (hs1_s) begin
            win_we_s    = p1_we;
            win_addr_s  = p1_addr;
            win_wdata_s = p1_wdata;
        end else if (hs0_s) begin
            win_we_s    = p0_we;
            win_addr_s  = p0_addr;
            win_wdata_s = p0_wdata;
        end else begin
            win_we_s    = 1'b0;
            win_addr_s  = '0;
            win_wdata_s = 32'h0000_0000;
        end
    end

    // Misaligned accesses are accepted but never reach the memory.
    assign win_ok_s  = addr_aligned(win_addr_s[1:0]);
    assign mem_read  = grant_valid_s & win_ok_s & ~win_we_s;
    assign mem_write = grant_valid_s & win_ok_s & win_we_s;
    assign mem_addr  = win_addr_s;
    assign mem_wdata = win_wdata_s;

    // Next-state for responses and the last-grant pointer.
    always_comb begin
        rsp0_d = next_rsp(hs0_s, win_ok_s, win_we_s, mem_rdata, rsp0_q.rdata);
        rsp1_d = next_rsp(hs1_s, win_ok_s, win_we_s, mem_rdata, rsp1_q.rdata);
        if (grant_valid_s) begin
            last_grant_d = grant_port_s;
        end else begin
            last_grant_d = last_grant_q;
        end
    end

    // Response registers and last-grant pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp0_q       <= '0;
            rsp1_q       <= '0;
            last_grant_q <= PORT_DBG;
        end else begin
            rsp0_q       <= rsp0_d;
            rsp1_q       <= rsp1_d;
            last_grant_q <= last_grant_d;
        end
    end

`ifndef DMEM_ARB_RR_EN
    localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] starve_cnt_d, starve_cnt_q;

    // Count consecutive cycles port 1 waits while port 0 is served.
    always_comb begin
        if (!v1_s || hs1_s) begin
            starve_cnt_d = '0;
        end else if (hs0_s && (starve_cnt_q != LIMIT_C)) begin
            starve_cnt_d = starve_cnt_q + CNT_W'(1);
        end else begin
            starve_cnt_d = starve_cnt_q;
        end
    end

    // Starvation counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

    assign starve_hit_s = (starve_cnt_q == LIMIT_C);
`else
    assign starve_hit_s = 1'b0;
`endif

    assign p0_rvalid = rsp0_q.rvalid;
    assign p0_err    = rsp0_q.err;
    assign p0_rdata  = rsp0_q.rdata;
    assign p1_rvalid = rsp1_q.rvalid;
    assign p1_err    = rsp1_q.err;
    assign p1_rdata  = rsp1_q.rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized scoreboard bench for dmem_arbiter with a behavioural memory
// model. Honours DMEM_ARB_RR_EN to select the expected arbitration rule.
module tb_dmem_arbiter;

    localparam int LIMIT = 8;

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        p0_valid, p0_ready, p0_we, p0_rvalid, p0_err;
    logic [31:0] p0_addr, p0_wdata, p0_rdata;
    logic        p1_valid, p1_ready, p1_we, p1_rvalid, p1_err;
    logic [31:0] p1_addr, p1_wdata, p1_rdata;
    logic        mem_read, mem_write;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    // memory device seen by the DUT
    logic [31:0] dev_mem [64] = '{4: 32'hDEAD_BEEF, default: 32'h0000_0000};
    // reference model state
    logic [31:0] ref_mem [64];
    logic [31:0] last_rd [2];
    int          losses;
    int          last_win;
    exp_t        exp_q0[$];
    exp_t        exp_q1[$];
    exp_t        m0, m1;
    // pending requests held by the requesters until accepted
    bit          pv  [2];
    bit          pwe [2];
    logic [31:0] paddr [2];
    logic [31:0] pwd   [2];

    always #5 clk = ~clk;

    assign mem_rdata = dev_mem[mem_addr[7:2]];

    always @(posedge clk) begin
        if (mem_write) dev_mem[mem_addr[7:2]] <= mem_wdata;
    end

    dmem_arbiter #(.STARVE_LIMIT(LIMIT), .ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_we(p0_we), .p0_addr(p0_addr),
        .p0_wdata(p0_wdata), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata), .p0_err(p0_err),
        .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_we(p1_we), .p1_addr(p1_addr),
        .p1_wdata(p1_wdata), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata), .p1_err(p1_err),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Arbitration rule from the requirements, in terms of who is waiting.
    function automatic int model_pick(bit v0, bit v1);
        if (!v0 && !v1) return -1;
        if (v0 && !v1) return 0;
        if (v1 && !v0) return 1;
`ifdef DMEM_ARB_RR_EN
        return 1 - last_win;
`else
        return (losses == LIMIT) ? 1 : 0;
`endif
    endfunction

    function automatic void model_reset();
        losses     = 0;
        last_win   = 1;
        last_rd[0] = 32'h0;
        last_rd[1] = 32'h0;
    endfunction

    task automatic issue(input int p, input bit we, input logic [31:0] a, input logic [31:0] d);
        pv[p] = 1'b1; pwe[p] = we; paddr[p] = a; pwd[p] = d;
    endtask

    // One clock cycle: present pending requests, predict the winner and the
    // memory-side strobes, queue the expected response.
    task automatic step(output int win);
        logic [31:0] a;
        bit          ok, v1;
        exp_t        e;
        @(negedge clk);
        p0_valid = pv[0]; p0_we = pwe[0]; p0_addr = paddr[0]; p0_wdata = pwd[0];
        p1_valid = pv[1]; p1_we = pwe[1]; p1_addr = paddr[1]; p1_wdata = pwd[1];
        #1;
        v1  = pv[1];
        win = model_pick(pv[0], pv[1]);
        check("p0_ready", 32'(p0_ready), 32'(win == 0));
        check("p1_ready", 32'(p1_ready), 32'(win == 1));
        if (win >= 0) begin
            a  = paddr[win];
            ok = (a[1:0] == 2'b00);
            check("mem_read", 32'(mem_read), 32'(ok && !pwe[win]));
            check("mem_write", 32'(mem_write), 32'(ok && pwe[win]));
            check("mem_addr", mem_addr, a);
            if (ok && pwe[win]) check("mem_wdata", mem_wdata, pwd[win]);
            e.err = !ok;
            e.rdata = (ok && !pwe[win]) ? ref_mem[a[7:2]] : last_rd[win];
            last_rd[win] = e.rdata;
            if (ok && pwe[win]) ref_mem[a[7:2]] = pwd[win];
            if (win == 0) exp_q0.push_back(e); else exp_q1.push_back(e);
            last_win = win;
            pv[win]  = 1'b0;
        end else begin
            check("idle_mem_read", 32'(mem_read), 32'd0);
            check("idle_mem_write", 32'(mem_write), 32'd0);
            check("idle_mem_addr", mem_addr, 32'd0);
            check("idle_mem_wdata", mem_wdata, 32'd0);
        end
        if (v1 && win == 0) losses = (losses < LIMIT) ? losses + 1 : LIMIT;
        else losses = 0;
    endtask

    task automatic check_reset_outputs();
        p0_valid = 1'b1; p1_valid = 1'b1;
        #1;
        check("rst_p0_ready", 32'(p0_ready), 32'd0);
        check("rst_p1_ready", 32'(p1_ready), 32'd0);
        check("rst_p0_rvalid", 32'(p0_rvalid), 32'd0);
        check("rst_p1_rvalid", 32'(p1_rvalid), 32'd0);
        check("rst_p0_err", 32'(p0_err), 32'd0);
        check("rst_p1_err", 32'(p1_err), 32'd0);
        check("rst_p0_rdata", p0_rdata, 32'd0);
        check("rst_p1_rdata", p1_rdata, 32'd0);
        check("rst_mem_read", 32'(mem_read), 32'd0);
        check("rst_mem_write", 32'(mem_write), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
    endtask

    // Monitor: every cycle, a queued expectation must appear as an rvalid
    // pulse with matching err/rdata; otherwise rvalid must be low.
    always @(negedge clk) begin
        if (exp_q0.size() > 0) begin
            m0 = exp_q0.pop_front();
            check("p0_rvalid", 32'(p0_rvalid), 32'd1);
            check("p0_err", 32'(p0_err), 32'(m0.err));
            check("p0_rdata", p0_rdata, m0.rdata);
        end else begin
            check("p0_rvalid_idle", 32'(p0_rvalid), 32'd0);
        end
        if (exp_q1.size() > 0) begin
            m1 = exp_q1.pop_front();
            check("p1_rvalid", 32'(p1_rvalid), 32'd1);
            check("p1_err", 32'(p1_err), 32'(m1.err));
            check("p1_rdata", p1_rdata, m1.rdata);
        end else begin
            check("p1_rvalid_idle", 32'(p1_rvalid), 32'd0);
        end
    end

    initial begin
        int w;
        int got;
        for (int i = 0; i < 64; i++) ref_mem[i] = 32'h0;
        ref_mem[4] = 32'hDEAD_BEEF;
        model_reset();
        for (int p = 0; p < 2; p++) begin
            pv[p] = 1'b0; pwe[p] = 1'b0; paddr[p] = 32'h0; pwd[p] = 32'h0;
        end
        p0_we = 1'b0; p0_addr = 32'h10; p0_wdata = 32'h0;
        p1_we = 1'b0; p1_addr = 32'h14; p1_wdata = 32'h0;

        // reset state with both ports requesting
        #12;
        check_reset_outputs();
        @(posedge clk); #2;
        rst_n = 1'b1; p0_valid = 1'b0; p1_valid = 1'b0;

`ifdef DMEM_ARB_RR_EN
        // contention alternates, port 0 first
        for (int i = 0; i < 6; i++) begin
            if (!pv[0]) issue(0, 1'b0, 32'h20, 32'h0);
            if (!pv[1]) issue(1, 1'b0, 32'h24, 32'h0);
            step(w);
            check("rr_grant", 32'(w), 32'(i % 2));
        end
        pv[0] = 1'b0; pv[1] = 1'b0;
        step(w);
`endif

        // sole p0 load of word 4
        issue(0, 1'b0, 32'h10, 32'h0);
        step(w);
        @(posedge clk); #1;
        check("load_rvalid", 32'(p0_rvalid), 32'd1);
        check("load_rdata", p0_rdata, 32'hDEAD_BEEF);

        // simultaneous stores, then readback
        issue(0, 1'b1, 32'h04, 32'h11);
        issue(1, 1'b1, 32'h08, 32'h22);
        step(w);
        check("both_first", 32'(w), 32'd0);
        step(w);
        check("both_second", 32'(w), 32'd1);
        issue(0, 1'b0, 32'h04, 32'h0);
        step(w);
        @(posedge clk); #1;
        check("readback_04", p0_rdata, 32'h11);
        issue(1, 1'b0, 32'h08, 32'h0);
        step(w);
        @(posedge clk); #1;
        check("readback_08", p1_rdata, 32'h22);

`ifndef DMEM_ARB_RR_EN
        // starvation guard: p1 wins on the 9th contended cycle
        got = 0;
        issue(1, 1'b0, 32'h20, 32'h0);
        for (int i = 1; i <= 20 && got == 0; i++) begin
            if (!pv[0]) issue(0, 1'b0, {24'd0, 6'($urandom_range(0, 63)), 2'b00}, 32'h0);
            step(w);
            if (w == 1) got = i;
        end
        check("starve_grant_cycle", 32'(got), 32'd9);
        issue(1, 1'b0, 32'h24, 32'h0);
        if (!pv[0]) issue(0, 1'b0, 32'h28, 32'h0);
        step(w);
        check("starve_cleared", 32'(w), 32'd0);
        step(w);
`endif

        // misaligned p1 load
        issue(1, 1'b0, 32'h0A, 32'h0);
        step(w);
        @(posedge clk); #1;
        check("misal_rvalid", 32'(p1_rvalid), 32'd1);
        check("misal_err", 32'(p1_err), 32'd1);

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            for (int p = 0; p < 2; p++) begin
                if (!pv[p] && $urandom_range(0, 9) < 6) begin
                    issue(p, 1'($urandom_range(0, 1)),
                          {24'd0, 6'($urandom_range(0, 63)),
                           ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00},
                          $urandom);
                end
            end
            step(w);
        end
        for (int n = 0; n < 20 && (pv[0] || pv[1]); n++) step(w);
        step(w);

        // reset during an outstanding load response
        issue(0, 1'b0, 32'h10, 32'h0);
        step(w);
        @(posedge clk); #2;
        rst_n = 1'b0;
        exp_q0.delete();
        exp_q1.delete();
        model_reset();
        pv[0] = 1'b0; pv[1] = 1'b0;
        check_reset_outputs();
        @(posedge clk); #2;
        rst_n = 1'b1; p0_valid = 1'b0; p1_valid = 1'b0;
        #1;
        check("post_rst_p0_rdata", p0_rdata, 32'd0);
        repeat (3) step(w);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
